pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the five-stage CPU pipeline. Each cycle it decides which pipeline barriers may load, which are flushed to bubbles, and whether the PC advances. Three event sources drive it:

- load-use hazards between ID and EX;
- taken branches resolved in EX;
- multi-cycle data-memory accesses in MEM.

It also keeps stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/cpu_control_pkg.sv | 13 +
 rtl/hazard_detector.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_pkg.sv
// Shared control definitions for the CPU pipeline control blocks.
// Holds the sequencer state encoding and register-index constants.
package cpu_control_pkg;

    localparam int REG_IDX_WIDTH = 5;
    localparam logic [REG_IDX_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_detector.sv
// Combinational load-use hazard detection between the ID and EX stages.
// Writes to x0 are discarded by the register file, so they never form a hazard.
module hazard_detector
    import cpu_control_pkg::*;
(
    input  logic [REG_IDX_WIDTH-1:0] idRs1,
    input  logic [REG_IDX_WIDTH-1:0] idRs2,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  logic [REG_IDX_WIDTH-1:0] exRd,
    input  logic                     exIsMemRead,
    input  logic                     exIsRegisterWrite,
    output logic                     loadUse
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = idUsesRs1 && (idRs1 == exRd);
    assign rs2_match = idUsesRs2 && (idRs2 == exRd);
    assign loadUse   = exIsMemRead && exIsRegisterWrite && (exRd != REG_ZERO)
                       && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: barrier enables, bubbles,
// PC hold, memory-wait tracking and stall/flush performance counters.
module pipeline_hazard_controller
    import cpu_control_pkg::*;
#(
    parameter int WAIT_LIMIT    = 64,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_IDX_WIDTH-1:0] idRs1,
    input  logic [REG_IDX_WIDTH-1:0] idRs2,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  logic [REG_IDX_WIDTH-1:0] exRd,
    input  logic                     exIsMemRead,
    input  logic                     exIsRegisterWrite,
    input  logic                     exBranchTaken,
    input  logic                     memRequest,
    input  logic                     memReady,
    output logic                     pcWrite,
    output logic                     ifIdWrite,
    output logic                     ifIdFlush,
    output logic                     idExWrite,
    output logic                     idExFlush,
    output logic                     exMemWrite,
    output logic                     memWbFlush,
    output logic [COUNTER_WIDTH-1:0] stallCycles,
    output logic [COUNTER_WIDTH-1:0] flushCount,
    output logic                     memTimeout,
    output state_t                   fsmState
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(WAIT_LIMIT - 1);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_count;
    logic                load_use;
    logic                mem_stall;
    logic                branch_flush;

    hazard_detector u_hazard_detector (
        .idRs1             (idRs1),
        .idRs2             (idRs2),
        .idUsesRs1         (idUsesRs1),
        .idUsesRs2         (idUsesRs2),
        .exRd              (exRd),
        .exIsMemRead       (exIsMemRead),
        .exIsRegisterWrite (exIsRegisterWrite),
        .loadUse           (load_use)
    );

    assign mem_stall    = memRequest && !memReady;
    assign branch_flush = !reset && !mem_stall && exBranchTaken;
    assign fsmState     = state_q;

    // A dropped memRequest in MEM_WAIT is a protocol error; it simply returns to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_stall) state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Priority: reset > memory stall > taken branch > load-use > normal.
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExWrite  = 1'b1;
        idExFlush  = 1'b0;
        exMemWrite = 1'b1;
        memWbFlush = 1'b0;
        if (reset) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            memWbFlush = 1'b1;
        end else if (mem_stall) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
        end else if (exBranchTaken) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (load_use) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_count  <= '0;
            memTimeout  <= 1'b0;
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            state_q <= state_d;
            if (mem_stall) begin
                if (wait_count != WAIT_MAX) wait_count <= wait_count + 1'b1;
                if (wait_count >= WAIT_PRE) memTimeout <= 1'b1;
            end else begin
                wait_count <= '0;
            end
            if (!pcWrite && (stallCycles != '1)) stallCycles <= stallCycles + 1'b1;
            if (branch_flush && (flushCount != '1)) flushCount <= flushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a rule-level reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_pipeline_hazard_controller;
    import cpu_control_pkg::*;

    localparam int LIMIT = 4;
    localparam int CW    = 32;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] idRs1, idRs2, exRd;
    logic idUsesRs1, idUsesRs2, exIsMemRead, exIsRegisterWrite;
    logic exBranchTaken, memRequest, memReady;
    logic pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush;
    logic [CW-1:0] stallCycles, flushCount;
    logic memTimeout;
    state_t fsmState;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp_q[$];

    // model state
    bit m_in_wait = 0;
    int m_wait = 0;
    bit m_timeout = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    pipeline_hazard_controller #(.WAIT_LIMIT(LIMIT), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .exRd(exRd), .exIsMemRead(exIsMemRead), .exIsRegisterWrite(exIsRegisterWrite),
        .exBranchTaken(exBranchTaken), .memRequest(memRequest), .memReady(memReady),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
        .memWbFlush(memWbFlush), .stallCycles(stallCycles), .flushCount(flushCount),
        .memTimeout(memTimeout), .fsmState(fsmState)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard: expected {pc, ifIdW, ifIdF, idExW, idExF, exMemW, memWbF}
    always @(negedge clk) begin
        bit ms, lu, br;
        logic [6:0] exp_v;
        logic [6:0] got_v;
        ms = memRequest && !memReady;
        lu = exIsMemRead && exIsRegisterWrite && (exRd != 5'd0) &&
             ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
        br = 0;
        if (reset)              exp_v = 7'b0_0_1_0_1_0_1;
        else if (ms)            exp_v = 7'b0_0_0_0_0_0_1;
        else if (exBranchTaken) begin exp_v = 7'b1_1_1_1_1_1_0; br = 1; end
        else if (lu)            exp_v = 7'b0_0_0_1_1_1_0;
        else                    exp_v = 7'b1_1_0_1_0_1_0;
        exp_q.push_back(exp_v);
        got_v = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush};
        check("ctrl", got_v, exp_q.pop_front());
        check("stallCycles", stallCycles, m_stall);
        check("flushCount", flushCount, m_flush);
        check("memTimeout", memTimeout, m_timeout);
        check("state", fsmState == MEM_WAIT, m_in_wait);
        if (reset) begin
            m_in_wait = 0; m_wait = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_in_wait = ms;
            if (ms) begin
                if (m_wait + 1 >= LIMIT) m_timeout = 1;
                m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
            end else m_wait = 0;
            if (!exp_v[6]) m_stall++;
            if (br) m_flush++;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0; exRd = 0;
        exIsMemRead = 0; exIsRegisterWrite = 0; exBranchTaken = 0;
        memRequest = 0; memReady = 0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2);
        exIsMemRead = 1; exIsRegisterWrite = 1; exRd = rd;
        idRs1 = rs1; idRs2 = rs2; idUsesRs1 = u1; idUsesRs2 = u2;
    endtask

    task automatic do_reset();
        reset = 1; idle(); step(); reset = 0;
    endtask

    initial begin
        reset = 1; idle();
        step(); step();
        reset = 0;
        check("rst_stall", stallCycles, 0);
        check("rst_flush", flushCount, 0);
        check("rst_timeout", memTimeout, 0);
        #1 check("idle_pc", pcWrite, 1);
        step();

        // load-use on rs1
        load_use(5, 5, 0, 1, 0);
        #1 check("lu_pc", pcWrite, 0);
        check("lu_idExFlush", idExFlush, 1);
        step(); idle(); step();
        check("lu_stall", stallCycles, 1);

        // x0 never hazards
        load_use(0, 0, 0, 1, 1);
        #1 check("x0_pc", pcWrite, 1);
        step(); idle();
        // rs2 match only
        load_use(9, 1, 9, 1, 1); step();
        // rs2 matches but unused
        load_use(9, 1, 9, 1, 0); step(); idle(); step();
        check("lu2_stall", stallCycles, 2);

        // branch with simultaneous load-use
        load_use(5, 5, 0, 1, 0); exBranchTaken = 1;
        #1 check("br_pc", pcWrite, 1);
        check("br_ifIdFlush", ifIdFlush, 1);
        step(); idle(); step();
        check("br_flush", flushCount, 1);
        check("br_stall", stallCycles, 2);

        // memory wait, 3 cycles
        memRequest = 1; memReady = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_exMem", exMemWrite, 0);
            step();
            check("mw_state", fsmState == MEM_WAIT, 1);
        end
        memReady = 1; step(); idle();
        check("mw_run", fsmState == MEM_WAIT, 0);
        check("mw_stall", stallCycles, 5);
        check("mw_timeout", memTimeout, 0);
        step();

        // memory stall with branch
        do_reset();
        memRequest = 1; exBranchTaken = 1;
        step(); step();
        check("msb_noflush", flushCount, 0);
        memReady = 1; step(); idle(); step();
        check("msb_flush", flushCount, 1);

        // timeout
        do_reset();
        memRequest = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("to_timeout", memTimeout, (i >= LIMIT) ? 1'b1 : 1'b0);
        end
        memReady = 1; step(); idle(); step();
        check("to_sticky", memTimeout, 1);

        // protocol error: request drops during wait
        do_reset();
        memRequest = 1; step(); step();
        memRequest = 0; step();
        check("perr_state", fsmState == MEM_WAIT, 0);
        check("perr_timeout", memTimeout, 0);

        // reset mid-wait
        memRequest = 1; step(); step();
        check("rmw_in_wait", fsmState == MEM_WAIT, 1);
        reset = 1;
        #1 check("rmw_pc", pcWrite, 0);
        check("rmw_memWbFlush", memWbFlush, 1);
        step(); reset = 0; idle();
        check("rmw_state", fsmState == MEM_WAIT, 0);
        check("rmw_stall", stallCycles, 0);
        check("rmw_timeout", memTimeout, 0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
